// File: rtl/pc_seq_if.sv
// pc_seq_if: fetch-control bundle between the hazard/branch logic and the
// pc_sequencer. The master side drives control and redirect requests and
// receives the fetch address; the slave side is the sequencer itself.
interface pc_seq_if #(
  parameter int ADDR_W  = 32,
  parameter int COUNT_W = 32
);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              exc_valid;
  logic              call_push;
  logic              ret_pop;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus_step;
  logic              pc_valid;
  logic              align_err;
  logic [COUNT_W-1:0] fetch_count;
  logic              ras_underflow;

  modport master (
    output stall, redirect_valid, redirect_target, exc_valid, call_push, ret_pop,
    input  pc, pc_plus_step, pc_valid, align_err, fetch_count, ras_underflow
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, exc_valid, call_push, ret_pop,
    output pc, pc_plus_step, pc_valid, align_err, fetch_count, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter.
// Next-pc priority: rst > exception > redirect > stall > return-stack pop > pc+STEP.
// Optional feature macro PC_RAS_EN adds a RAS_DEPTH-entry circular return-address
// stack (RAS_DEPTH a power of two, >= 2); without it call_push/ret_pop are ignored
// and ras_underflow is held at 0.
module pc_sequencer #(
  parameter int                 ADDR_W       = 32,
  parameter int                 STEP         = 4,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR   = ADDR_W'('h80),
  parameter int                 COUNT_W      = 32,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_seq_if.slave  bus
);

  localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  // Clear the sub-STEP offset bits of a redirect target.
  function automatic logic [ADDR_W-1:0] align_tgt(input logic [ADDR_W-1:0] t);
    return t & ~ALIGN_MASK;
  endfunction

  logic [ADDR_W-1:0]  pc_p1;
  logic [ADDR_W-1:0]  pc_nxt;
  logic               vld_p1;
  logic               align_p1;
  logic               unf_p1;
  logic [COUNT_W-1:0] cnt_p1;
  logic               advance;
  logic               misaligned;
  logic               ras_hit;
  logic               ras_unf;
  logic [ADDR_W-1:0]  ras_top;

  assign bus.pc_plus_step  = pc_p1 + STEP_A;
  assign bus.pc            = pc_p1;
  assign bus.pc_valid      = vld_p1;
  assign bus.align_err     = align_p1;
  assign bus.fetch_count   = cnt_p1;
  assign bus.ras_underflow = unf_p1;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  // Occupancy saturates at RAS_DEPTH: a push onto a full stack overwrites the oldest slot.
  function automatic logic [OCC_W-1:0] occ_inc_sat(input logic [OCC_W-1:0] occ);
    return (occ == OCC_W'(RAS_DEPTH)) ? occ : occ + OCC_W'(1);
  endfunction

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_tp_p1;   // next free slot; top of stack is one below
  logic [OCC_W-1:0]  ras_occ_p1;
  logic [PTR_W-1:0]  ras_top_idx;
  logic              ras_gate;
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;

  assign ras_gate    = ~bus.stall & ~bus.redirect_valid & ~bus.exc_valid;
  assign ras_push    = ras_gate & bus.call_push;
  assign ras_pop     = ras_gate & bus.ret_pop;
  assign ras_empty   = (ras_occ_p1 == '0);
  assign ras_hit     = ras_pop & ~ras_empty;
  assign ras_unf     = ras_pop & ras_empty;
  assign ras_top_idx = ras_tp_p1 - PTR_W'(1);
  assign ras_top     = ras_mem[ras_top_idx];

  // Stack pointer and occupancy; a simultaneous push+pop replaces the top in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_tp_p1  <= '0;
      ras_occ_p1 <= '0;
    end else if (ras_hit && !ras_push) begin
      ras_tp_p1  <= ras_top_idx;
      ras_occ_p1 <= ras_occ_p1 - OCC_W'(1);
    end else if (ras_push && !ras_hit) begin
      ras_tp_p1  <= ras_tp_p1 + PTR_W'(1);
      ras_occ_p1 <= occ_inc_sat(ras_occ_p1);
    end
  end

  // Return-address storage; contents are meaningless while occupancy is zero.
  always_ff @(posedge clk) begin
    if (ras_hit && ras_push) begin
      ras_mem[ras_top_idx] <= bus.pc_plus_step;
    end else if (ras_push) begin
      ras_mem[ras_tp_p1] <= bus.pc_plus_step;
    end
  end
`else
  logic unused_ras;
  assign unused_ras = &{1'b0, bus.call_push, bus.ret_pop, RAS_DEPTH[0]};
  assign ras_hit    = 1'b0;
  assign ras_unf    = 1'b0;
  assign ras_top    = '0;
`endif

  assign advance    = bus.exc_valid | bus.redirect_valid | ~bus.stall;
  assign misaligned = bus.redirect_valid & ~bus.exc_valid &
                      (|(bus.redirect_target & ALIGN_MASK));

  // Next-pc select in priority order.
  always_comb begin
    pc_nxt = bus.pc_plus_step;
    if (bus.exc_valid) begin
      pc_nxt = EXC_VECTOR;
    end else if (bus.redirect_valid) begin
      pc_nxt = align_tgt(bus.redirect_target);
    end else if (bus.stall) begin
      pc_nxt = pc_p1;
    end else if (ras_hit) begin
      pc_nxt = ras_top;
    end
  end

  // Stage p1: pc, valid, status pulses and the retired-fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1    <= RESET_VECTOR;
      vld_p1   <= 1'b0;
      align_p1 <= 1'b0;
      unf_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      pc_p1    <= pc_nxt;
      vld_p1   <= 1'b1;
      align_p1 <= misaligned;
      unf_p1   <= ras_unf;
      if (vld_p1 && advance) begin
        cnt_p1 <= cnt_p1 + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios followed by randomized control traffic,
// compared every cycle against a queue-based reference model of the fetch pc.
module tb_pc_sequencer;
  localparam int CW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  pc_seq_if #(.ADDR_W(32), .COUNT_W(CW)) bus();

  pc_sequencer #(
    .ADDR_W(32), .STEP(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80),
    .COUNT_W(CW), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference state
  logic [31:0] m_pc;
  bit          m_vld;
  bit          m_align;
  bit          m_unf;
  int unsigned m_cnt;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one clock edge worth of rules to the reference state.
  task automatic model_edge(input bit r, input bit s, input bit rv, input logic [31:0] tg,
                            input bit e, input bit cp, input bit rp);
    logic [31:0] ret_pc;
    if (r) begin
      m_pc = 32'h0; m_vld = 0; m_align = 0; m_unf = 0; m_cnt = 0;
      m_ras.delete();
      return;
    end
    if (m_vld && (e || rv || !s)) m_cnt = (m_cnt + 1) % (1 << CW);
    m_align = 0;
    m_unf   = 0;
    if (e) begin
      m_pc = 32'h80;
    end else if (rv) begin
      m_pc    = {tg[31:2], 2'b00};
      m_align = (tg[1:0] != 2'b00);
    end else if (s) begin
      m_pc = m_pc;
    end else begin
`ifdef PC_RAS_EN
      if (rp && m_ras.size() > 0) begin
        ret_pc = m_ras[m_ras.size()-1];
        if (cp) m_ras[m_ras.size()-1] = m_pc + 32'd4;
        else    void'(m_ras.pop_back());
        m_pc = ret_pc;
      end else begin
        if (rp) m_unf = 1;
        if (cp) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        m_pc = m_pc + 32'd4;
      end
`else
      ret_pc = 32'h0;
      m_pc   = m_pc + 32'd4 + ret_pc + {31'b0, cp & 1'b0} + {31'b0, rp & 1'b0};
`endif
    end
    m_vld = 1;
  endtask

  // Drive inputs, take one edge, then compare every output against the model.
  task automatic cyc(input string tag, input bit r, input bit s, input bit rv,
                     input logic [31:0] tg, input bit e, input bit cp, input bit rp);
    rst = r; bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = tg;
    bus.exc_valid = e; bus.call_push = cp; bus.ret_pop = rp;
    @(posedge clk);
    model_edge(r, s, rv, tg, e, cp, rp);
    #1;
    check({tag, "_pc"},    {32'b0, bus.pc},           {32'b0, m_pc});
    check({tag, "_pcps"},  {32'b0, bus.pc_plus_step}, {32'b0, m_pc + 32'd4});
    check({tag, "_vld"},   {63'b0, bus.pc_valid},     {63'b0, m_vld});
    check({tag, "_align"}, {63'b0, bus.align_err},    {63'b0, m_align});
    check({tag, "_cnt"},   {56'b0, bus.fetch_count},  64'(m_cnt));
    check({tag, "_unf"},   {63'b0, bus.ras_underflow}, {63'b0, m_unf});
  endtask

  initial begin
    rst = 1'b1; bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = '0;
    bus.exc_valid = 0; bus.call_push = 0; bus.ret_pop = 0;
    m_pc = 0; m_vld = 0; m_align = 0; m_unf = 0; m_cnt = 0;

    // Reset, then sequential fetch
    cyc("rst", 1, 0, 0, 0, 0, 0, 0);
    check("t1_rst_pc", {32'b0, bus.pc}, 64'h0);
    check("t1_rst_vld", {63'b0, bus.pc_valid}, 64'h0);
    for (int i = 0; i < 3; i++) cyc("t1_seq", 0, 0, 0, 0, 0, 0, 0);
    check("t1_pc_c", {32'b0, bus.pc}, 64'hC);

    // Stall hold, then redirect overriding stall
    cyc("rst2", 1, 0, 0, 0, 0, 0, 0);
    cyc("t2_seq", 0, 0, 0, 0, 0, 0, 0);
    cyc("t2_seq", 0, 0, 0, 0, 0, 0, 0);
    cyc("t2_stall", 0, 1, 0, 0, 0, 0, 0);
    cyc("t2_stall", 0, 1, 0, 0, 0, 0, 0);
    check("t2_hold_pc", {32'b0, bus.pc}, 64'h8);
    cyc("t2_stredir", 0, 1, 1, 32'h40, 0, 0, 0);
    check("t2_redir_pc", {32'b0, bus.pc}, 64'h40);

    // Exception over redirect; misaligned redirect pulse
    cyc("t3_exc", 0, 0, 1, 32'h40, 1, 0, 0);
    check("t3_exc_pc", {32'b0, bus.pc}, 64'h80);
    cyc("t3_mis", 0, 0, 1, 32'h42, 0, 0, 0);
    check("t3_mis_pc", {32'b0, bus.pc}, 64'h40);
    check("t3_mis_err", {63'b0, bus.align_err}, 64'h1);
    cyc("t3_after", 0, 0, 0, 0, 0, 0, 0);
    check("t3_err_clr", {63'b0, bus.align_err}, 64'h0);

    // Address wrap
    cyc("t4_redir", 0, 0, 1, 32'hFFFFFFF8, 0, 0, 0);
    cyc("t4_seq", 0, 0, 0, 0, 0, 0, 0);
    check("t4_top", {32'b0, bus.pc}, 64'hFFFFFFFC);
    cyc("t4_seq", 0, 0, 0, 0, 0, 0, 0);
    check("t4_wrap", {32'b0, bus.pc}, 64'h0);
    cyc("t4_seq", 0, 0, 0, 0, 0, 0, 0);
    check("t4_four", {32'b0, bus.pc}, 64'h4);

`ifdef PC_RAS_EN
    // Call/return pairing and underflow
    cyc("t5_rst", 1, 0, 0, 0, 0, 0, 0);
    cyc("t5_r10", 0, 0, 1, 32'h10, 0, 0, 0);
    cyc("t5_call", 0, 0, 0, 0, 0, 1, 0);
    cyc("t5_r20", 0, 0, 1, 32'h20, 0, 0, 0);
    cyc("t5_call", 0, 0, 0, 0, 0, 1, 0);
    cyc("t5_ret1", 0, 0, 0, 0, 0, 0, 1);
    check("t5_ret1_pc", {32'b0, bus.pc}, 64'h24);
    cyc("t5_ret2", 0, 0, 0, 0, 0, 0, 1);
    check("t5_ret2_pc", {32'b0, bus.pc}, 64'h14);
    cyc("t5_ret3", 0, 0, 0, 0, 0, 0, 1);
    check("t5_ret3_pc", {32'b0, bus.pc}, 64'h18);
    check("t5_ret3_unf", {63'b0, bus.ras_underflow}, 64'h1);

    // Overflow of a depth-4 stack, then reset empties it
    cyc("t6_rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("t6_call", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("t6_ret", 0, 0, 0, 0, 0, 0, 1);
    check("t6_ret4_pc", {32'b0, bus.pc}, 64'h8);
    cyc("t6_ret5", 0, 0, 0, 0, 0, 0, 1);
    check("t6_ret5_unf", {63'b0, bus.ras_underflow}, 64'h1);
    for (int i = 0; i < 3; i++) cyc("t6_call2", 0, 0, 0, 0, 0, 1, 0);
    cyc("t6_rst2", 1, 0, 0, 0, 0, 0, 0);
    cyc("t6_retr", 0, 0, 0, 0, 0, 0, 1);
    check("t6_retr_unf", {63'b0, bus.ras_underflow}, 64'h1);
`endif

    // Randomized traffic
    cyc("rnd_rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tg;
      tg = $urandom();
      if ($urandom_range(0, 1) == 0) tg[1:0] = 2'b00;
      cyc("rnd",
          ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0),
          tg,
          ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
